led_pattern_engine: RTL



---
 rtl/led_pattern_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern driver: a shared prescaler tick feeds N_CH independent
// off/on/blink/burst channels, each with a selectable half-period, gated by a global enable.
module led_pattern_engine #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned CLK_HZ    = 25_000_000,
   parameter int unsigned TICK_HZ   = 1000,
   parameter int unsigned HALF_0    = 5,
   parameter int unsigned HALF_1    = 10,
   parameter int unsigned HALF_2    = 50,
   parameter int unsigned HALF_3    = 500,
   parameter int unsigned BURST_LEN = 3,
   parameter int unsigned BURST_GAP = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [2*N_CH-1:0] i_mode,
   input  logic [2*N_CH-1:0] i_rate_sel,
   output logic [N_CH-1:0]   o_led_drive,
   output logic              o_tick
);

   localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HALF_01  = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
   localparam int unsigned HALF_23  = (HALF_2 > HALF_3) ? HALF_2 : HALF_3;
   localparam int unsigned HALF_MAX = (HALF_01 > HALF_23) ? HALF_01 : HALF_23;
   localparam int unsigned CNT_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
   localparam int unsigned PULSE_W  = $clog2(BURST_LEN + 1);
   localparam int unsigned GAP_W    = $clog2(BURST_GAP + 1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_GAP = 1'b1
   } burst_state_e;

   // Terminal count of the half-period counter for each rate selection
   function automatic logic [CNT_W-1:0] half_last(input logic [1:0] rate);
      logic [CNT_W-1:0] last;
      case (rate)
         2'd0:    last = CNT_W'(HALF_0 - 1);
         2'd1:    last = CNT_W'(HALF_1 - 1);
         2'd2:    last = CNT_W'(HALF_2 - 1);
         default: last = CNT_W'(HALF_3 - 1);
      endcase
      return last;
   endfunction

   logic [PRE_W-1:0] pre_q;
   logic             tick_c;
   logic [N_CH-1:0]  led_c;

   assign tick_c = (pre_q == PRE_W'(DIV - 1));

   // Shared prescaler and its monitor output
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pre_q  <= '0;
         o_tick <= 1'b0;
      end else begin
         pre_q  <= tick_c ? '0 : pre_q + PRE_W'(1);
         o_tick <= tick_c;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [1:0]         mode_c;
      logic [1:0]         rate_c;
      logic [1:0]         mode_q;
      logic [1:0]         rate_q;
      logic               restart_c;
      logic [CNT_W-1:0]   last_c;
      logic [CNT_W-1:0]   cnt_q;
      logic [CNT_W-1:0]   cnt_d;
      logic               phase_q;
      logic               phase_d;
      logic [PULSE_W-1:0] pulses_q;
      logic [PULSE_W-1:0] pulses_d;
      logic [GAP_W-1:0]   gap_q;
      logic [GAP_W-1:0]   gap_d;
      burst_state_e       state_q;
      burst_state_e       state_d;

      assign mode_c    = i_mode[2*k +: 2];
      assign rate_c    = i_rate_sel[2*k +: 2];
      assign restart_c = (mode_c != mode_q) || (rate_c != rate_q);
      assign last_c    = half_last(rate_q);

      // Config copy always tracks the inputs, so reset never triggers a restart
      always_ff @(posedge i_clock) begin
         mode_q <= mode_c;
         rate_q <= rate_c;
         if (i_reset) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            pulses_q <= '0;
            gap_q    <= '0;
            state_q  <= ST_RUN;
         end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            pulses_q <= pulses_d;
            gap_q    <= gap_d;
            state_q  <= state_d;
         end
      end

      always_comb begin
         cnt_d    = cnt_q;
         phase_d  = phase_q;
         pulses_d = pulses_q;
         gap_d    = gap_q;
         state_d  = state_q;
         if (restart_c) begin
            cnt_d    = '0;
            phase_d  = 1'b0;
            pulses_d = '0;
            gap_d    = '0;
            state_d  = ST_RUN;
         end else if (tick_c) begin
            if (cnt_q != last_c) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
               if ((mode_q == MODE_OFF) || (mode_q == MODE_ON)) begin
                  phase_d  = 1'b0;
                  pulses_d = '0;
                  gap_d    = '0;
                  state_d  = ST_RUN;
               end else if (state_q == ST_GAP) begin
                  phase_d = 1'b0;
                  if (gap_q == GAP_W'(BURST_GAP - 1)) begin
                     gap_d   = '0;
                     state_d = ST_RUN;
                  end else begin
                     gap_d = gap_q + GAP_W'(1);
                  end
               end else begin
                  phase_d = ~phase_q;
                  // A falling half-period in burst mode closes one pulse
                  if ((mode_q == MODE_BURST) && phase_q) begin
                     if (pulses_q == PULSE_W'(BURST_LEN - 1)) begin
                        pulses_d = '0;
                        phase_d  = 1'b0;
                        state_d  = ST_GAP;
                     end else begin
                        pulses_d = pulses_q + PULSE_W'(1);
                     end
                  end
               end
            end
         end
      end

      // Live mode picks the source so on/off changes show after one cycle
      always_comb begin
         led_c[k] = 1'b0;
         case (mode_c)
            MODE_ON:    led_c[k] = 1'b1;
            MODE_BLINK: led_c[k] = phase_q;
            MODE_BURST: led_c[k] = phase_q;
            default:    led_c[k] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_led_drive <= '0;
      end else begin
         o_led_drive <= led_c & {N_CH{i_enable}};
      end
   end

endmodule
